// File: rtl/prefetch_queue_pkg.sv
// ============================================================================
// Module      : prefetch_queue_pkg
// Description : Shared types and constants for the instruction prefetch queue.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

package prefetch_queue_pkg;

    localparam logic [31:0] RESET_PC_DEFAULT = 32'h8000_0000;

    typedef enum logic [1:0] {
        ST_FETCH  = 2'd0,
        ST_STALL  = 2'd1,
        ST_SQUASH = 2'd2
    } state_t;

    typedef struct packed {
        logic [31:0] inst;
        logic [31:0] pc;
    } entry_t;

    function automatic logic [31:0] align_word(input logic [31:0] addr);
        return {addr[31:2], 2'b00};
    endfunction

endpackage

`default_nettype wire

// File: rtl/prefetch_fifo.sv
// ============================================================================
// Module      : prefetch_fifo
// Description : Circular buffer of fetched {inst, pc} entries with occupancy.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module prefetch_fifo
    import prefetch_queue_pkg::*;
#(
    parameter int DEPTH = 4
) (
    input  logic                     clk,
    input  logic                     nrst,
    input  logic                     push,
    input  logic                     pop,
    input  logic                     flush,
    input  entry_t                   wdata,
    output entry_t                   head,
    output logic [$clog2(DEPTH):0]   count
);

    localparam int AW = $clog2(DEPTH);
    localparam logic [AW:0] FULL = (AW+1)'(DEPTH);

    entry_t        mem [DEPTH];
    logic [AW-1:0] wr_ptr;
    logic [AW-1:0] rd_ptr;
    logic          do_push;
    logic          do_pop;

    // A full queue still takes a push when the head leaves in the same cycle.
    assign do_pop  = pop && (count != '0);
    assign do_push = push && ((count != FULL) || do_pop);

    always_ff @(posedge clk) begin
        if (do_push && !flush) begin
            mem[wr_ptr] <= wdata;
        end
    end

    always_ff @(posedge clk or negedge nrst) begin
        if (!nrst) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else if (flush) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (do_push) begin
                wr_ptr <= wr_ptr + AW'(1);
            end
            if (do_pop) begin
                rd_ptr <= rd_ptr + AW'(1);
            end
            case ({do_push, do_pop})
                2'b10:   count <= count + (AW+1)'(1);
                2'b01:   count <= count - (AW+1)'(1);
                default: count <= count;
            endcase
        end
    end

    assign head = (count != '0) ? mem[rd_ptr] : '0;

endmodule

`default_nettype wire

// File: rtl/prefetch_queue.sv
// ============================================================================
// Module      : prefetch_queue
// Description : Instruction prefetcher feeding an RV32C fetch buffer; optional
//               statistics counters enabled by macro PREFETCH_STATS_EN.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module prefetch_queue
    import prefetch_queue_pkg::*;
#(
    parameter logic [31:0] RESET_PC = RESET_PC_DEFAULT,
    parameter int          DEPTH    = 4
) (
    input  logic                     clk,
    input  logic                     nrst,
    input  logic                     redirect_en,
    input  logic [31:0]              redirect_pc,
    output logic                     imem_ren,
    output logic [31:0]              imem_addr,
    input  logic                     imem_busy,
    input  logic [31:0]              imem_rdata,
    input  logic                     deq_en,
    output logic                     q_valid,
    output logic [31:0]              q_inst,
    output logic [31:0]              q_pc,
    output logic [$clog2(DEPTH):0]   q_count,
    output logic [31:0]              fetch_cnt,
    output logic [31:0]              squash_cnt
);

    localparam int          CW     = $clog2(DEPTH) + 1;
    localparam logic [CW-1:0] FULL   = CW'(DEPTH);
    localparam logic [CW-1:0] ALMOST = CW'(DEPTH - 1);

    state_t      state;
    logic        started;
    logic [31:0] fetch_pc;
    logic [31:0] squash_addr;
    logic        complete;
    logic        push;
    logic        pop_eff;
    logic        goes_full;
    entry_t      head;

    // The request line stays low during reset and for the first edge after it.
    assign imem_ren  = started && (state != ST_STALL);
    assign imem_addr = (state == ST_SQUASH) ? squash_addr : fetch_pc;
    assign complete  = imem_ren && !imem_busy;
    assign push      = complete && (state == ST_FETCH) && !redirect_en;
    assign pop_eff   = deq_en && q_valid;
    assign goes_full = push && !pop_eff && (q_count == ALMOST);

    prefetch_fifo #(
        .DEPTH (DEPTH)
    ) u_fifo (
        .clk   (clk),
        .nrst  (nrst),
        .push  (push),
        .pop   (deq_en),
        .flush (redirect_en),
        .wdata ('{inst: imem_rdata, pc: fetch_pc}),
        .head  (head),
        .count (q_count)
    );

    assign q_valid = (q_count != '0);
    assign q_inst  = head.inst;
    assign q_pc    = head.pc;

    always_ff @(posedge clk or negedge nrst) begin
        if (!nrst) begin
            state       <= ST_FETCH;
            started     <= 1'b0;
            fetch_pc    <= RESET_PC;
            squash_addr <= '0;
        end else begin
            started <= 1'b1;
            if (redirect_en) begin
                fetch_pc <= align_word(redirect_pc);
                // A stalled bus keeps the old address until its data is thrown away.
                if (imem_ren && imem_busy) begin
                    state <= ST_SQUASH;
                    if (state == ST_FETCH) begin
                        squash_addr <= fetch_pc;
                    end
                end else begin
                    state <= ST_FETCH;
                end
            end else begin
                case (state)
                    ST_FETCH: begin
                        if (complete) begin
                            fetch_pc <= fetch_pc + 32'd4;
                            if (goes_full) begin
                                state <= ST_STALL;
                            end
                        end
                    end
                    ST_STALL: begin
                        if (pop_eff || (q_count != FULL)) begin
                            state <= ST_FETCH;
                        end
                    end
                    ST_SQUASH: begin
                        if (complete) begin
                            state <= ST_FETCH;
                        end
                    end
                    default: state <= ST_FETCH;
                endcase
            end
        end
    end

`ifdef PREFETCH_STATS_EN
    logic [31:0] fetch_q;
    logic [31:0] squash_q;

    always_ff @(posedge clk or negedge nrst) begin
        if (!nrst) begin
            fetch_q  <= '0;
            squash_q <= '0;
        end else if (complete) begin
            fetch_q <= fetch_q + 32'd1;
            if (redirect_en || (state == ST_SQUASH)) begin
                squash_q <= squash_q + 32'd1;
            end
        end
    end

    assign fetch_cnt  = fetch_q;
    assign squash_cnt = squash_q;
`else
    assign fetch_cnt  = '0;
    assign squash_cnt = '0;
`endif

endmodule

`default_nettype wire

// File: tb/tb_prefetch_queue.sv
// ============================================================================
// Module      : tb_prefetch_queue
// Description : Directed testbench for prefetch_queue with a queue-based model.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_prefetch_queue;

    localparam int          DEPTH = 4;
    localparam logic [31:0] KEY   = 32'h5A5A_1234;
    localparam int          M_FETCH  = 0;
    localparam int          M_STALL  = 1;
    localparam int          M_SQUASH = 2;

    logic        clk;
    logic        nrst;
    logic        redirect_en;
    logic [31:0] redirect_pc;
    logic        imem_ren;
    logic [31:0] imem_addr;
    logic        imem_busy;
    logic [31:0] imem_rdata;
    logic        deq_en;
    logic        q_valid;
    logic [31:0] q_inst;
    logic [31:0] q_pc;
    logic [2:0]  q_count;
    logic [31:0] fetch_cnt;
    logic [31:0] squash_cnt;

    int checks = 0;
    int errors = 0;
    bit chk_on = 1'b0;

    prefetch_queue #(
        .RESET_PC (32'h8000_0000),
        .DEPTH    (DEPTH)
    ) dut (
        .clk         (clk),
        .nrst        (nrst),
        .redirect_en (redirect_en),
        .redirect_pc (redirect_pc),
        .imem_ren    (imem_ren),
        .imem_addr   (imem_addr),
        .imem_busy   (imem_busy),
        .imem_rdata  (imem_rdata),
        .deq_en      (deq_en),
        .q_valid     (q_valid),
        .q_inst      (q_inst),
        .q_pc        (q_pc),
        .q_count     (q_count),
        .fetch_cnt   (fetch_cnt),
        .squash_cnt  (squash_cnt)
    );

    // Memory image: every word is its own address scrambled by a key.
    assign imem_rdata = imem_addr ^ KEY;

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
        end
    endtask

    // Reference model: fetch mode, next fetch address, address held by a
    // request being discarded, and the queue contents as {inst, pc}.
    bit          m_started = 1'b0;
    int          m_mode    = M_FETCH;
    logic [31:0] m_pc      = 32'h8000_0000;
    logic [31:0] m_sq      = 32'h0;
    logic [63:0] mq[$];
    logic [31:0] m_fetch   = 32'h0;
    logic [31:0] m_squash  = 32'h0;
    bit          m_req;
    bit          m_cpl;
    logic [31:0] m_addr;

    always @(posedge clk or negedge nrst) begin
        if (!nrst) begin
            m_started = 1'b0;
            m_mode    = M_FETCH;
            m_pc      = 32'h8000_0000;
            m_sq      = 32'h0;
            mq.delete();
            m_fetch   = 32'h0;
            m_squash  = 32'h0;
        end else begin
            m_req  = m_started && (m_mode != M_STALL);
            m_addr = (m_mode == M_SQUASH) ? m_sq : m_pc;
            m_cpl  = m_req && !imem_busy;
            if (m_cpl) m_fetch = m_fetch + 1;
            if (redirect_en) begin
                if (m_cpl) m_squash = m_squash + 1;
                mq.delete();
                if (m_req && imem_busy) begin
                    if (m_mode == M_FETCH) m_sq = m_pc;
                    m_mode = M_SQUASH;
                end else begin
                    m_mode = M_FETCH;
                end
                m_pc = {redirect_pc[31:2], 2'b00};
            end else begin
                if (deq_en && mq.size() > 0) mq.delete(0);
                if (m_mode == M_FETCH && m_cpl) begin
                    mq.push_back({m_addr ^ KEY, m_addr});
                    m_pc = m_pc + 32'd4;
                    if (mq.size() == DEPTH) m_mode = M_STALL;
                end else if (m_mode == M_STALL && mq.size() < DEPTH) begin
                    m_mode = M_FETCH;
                end else if (m_mode == M_SQUASH && m_cpl) begin
                    m_squash = m_squash + 1;
                    m_mode   = M_FETCH;
                end
            end
            m_started = 1'b1;
        end
    end

    logic        e_ren;
    logic [63:0] e_head;

    always @(negedge clk) begin
        if (chk_on) begin
            e_ren = nrst && m_started && (m_mode != M_STALL);
            check("imem_ren", {31'b0, imem_ren}, {31'b0, e_ren});
            if (e_ren) begin
                check("imem_addr", imem_addr, (m_mode == M_SQUASH) ? m_sq : m_pc);
            end
            check("q_count", {29'b0, q_count}, mq.size());
            check("q_valid", {31'b0, q_valid}, {31'b0, mq.size() != 0});
            if (mq.size() != 0) begin
                e_head = mq[0];
                check("q_inst", q_inst, e_head[63:32]);
                check("q_pc", q_pc, e_head[31:0]);
            end
`ifdef PREFETCH_STATS_EN
            check("fetch_cnt", fetch_cnt, m_fetch);
            check("squash_cnt", squash_cnt, m_squash);
`else
            check("fetch_cnt", fetch_cnt, 32'h0);
            check("squash_cnt", squash_cnt, 32'h0);
`endif
        end
    end

    task automatic drive(input logic b, input logic d, input logic r, input logic [31:0] pc);
        imem_busy   = b;
        deq_en      = d;
        redirect_en = r;
        redirect_pc = pc;
        @(posedge clk);
        #2;
    endtask

    initial begin
        nrst = 1'b1;
        imem_busy = 1'b0;
        deq_en = 1'b0;
        redirect_en = 1'b0;
        redirect_pc = 32'h0;
        #1 nrst = 1'b0;
        #2 chk_on = 1'b1;
        repeat (3) @(posedge clk);
        #2;
        check("rst_ren", {31'b0, imem_ren}, 32'h0);
        check("rst_valid", {31'b0, q_valid}, 32'h0);
        check("rst_count", {29'b0, q_count}, 32'h0);
        check("rst_inst", q_inst, 32'h0);
        check("rst_pc", q_pc, 32'h0);
        nrst = 1'b1;

        // Fill from reset with zero-wait memory.
        repeat (5) drive(1'b0, 1'b0, 1'b0, 32'h0);
        check("fill_count", {29'b0, q_count}, 32'd4);
        check("fill_ren", {31'b0, imem_ren}, 32'h0);
        check("fill_head_pc", q_pc, 32'h8000_0000);
        check("fill_head_inst", q_inst, 32'hDA5A_1234);
        repeat (2) drive(1'b0, 1'b0, 1'b0, 32'h0);

        drive(1'b0, 1'b1, 1'b0, 32'h0);
        check("deq_head_pc", q_pc, 32'h8000_0004);
        check("deq_ren", {31'b0, imem_ren}, 32'h1);
        check("deq_next_addr", imem_addr, 32'h8000_0010);

        // Completion and dequeue together keep occupancy.
        drive(1'b0, 1'b1, 1'b0, 32'h0);
        check("both_count", {29'b0, q_count}, 32'd3);
        check("both_head_pc", q_pc, 32'h8000_0008);
        drive(1'b0, 1'b0, 1'b0, 32'h0);
        repeat (4) drive(1'b1, 1'b1, 1'b0, 32'h0);
        check("drain_valid", {31'b0, q_valid}, 32'h0);
        drive(1'b1, 1'b1, 1'b0, 32'h0);
        drive(1'b0, 1'b0, 1'b0, 32'h0);

        for (int i = 0; i < 40; i++) begin
            drive((i % 3) == 1, (i % 2) == 0, i == 17, 32'h0000_1003);
        end

        // Reset in the middle of a stalled transfer.
        drive(1'b1, 1'b0, 1'b0, 32'h0);
        nrst = 1'b0;
        #1;
        check("midrst_ren", {31'b0, imem_ren}, 32'h0);
        check("midrst_count", {29'b0, q_count}, 32'h0);
        @(posedge clk);
        #2;
        nrst = 1'b1;

        // Redirect while the bus is busy.
        repeat (3) drive(1'b0, 1'b0, 1'b0, 32'h0);
        drive(1'b1, 1'b0, 1'b0, 32'h0);
        drive(1'b1, 1'b0, 1'b1, 32'h8000_0102);
        check("sq_ren", {31'b0, imem_ren}, 32'h1);
        check("sq_addr", imem_addr, 32'h8000_0008);
        check("sq_valid", {31'b0, q_valid}, 32'h0);
        repeat (2) drive(1'b1, 1'b0, 1'b0, 32'h0);
        drive(1'b0, 1'b0, 1'b0, 32'h0);
        check("sq_done_addr", imem_addr, 32'h8000_0100);
        check("sq_done_valid", {31'b0, q_valid}, 32'h0);
        drive(1'b0, 1'b0, 1'b0, 32'h0);
        check("sq_new_pc", q_pc, 32'h8000_0100);
        check("sq_new_inst", q_inst, 32'hDA5A_1334);
`ifdef PREFETCH_STATS_EN
        check("stat_squash", squash_cnt, 32'd1);
        check("stat_fetch", fetch_cnt, 32'd4);
`else
        check("stat_squash", squash_cnt, 32'd0);
        check("stat_fetch", fetch_cnt, 32'd0);
`endif

        // Redirect with a completion and a dequeue in the same cycle.
        drive(1'b0, 1'b1, 1'b1, 32'h0000_0040);
        check("rc_count", {29'b0, q_count}, 32'h0);
        check("rc_addr", imem_addr, 32'h0000_0040);

        // Address wrap past the top of memory.
        drive(1'b0, 1'b0, 1'b1, 32'hFFFF_FFFB);
        repeat (3) drive(1'b0, 1'b0, 1'b0, 32'h0);
        check("wrap_addr", imem_addr, 32'h0000_0004);
        check("wrap_head", q_pc, 32'hFFFF_FFF8);
        check("wrap_count", {29'b0, q_count}, 32'd3);
        drive(1'b0, 1'b0, 1'b0, 32'h0);
        drive(1'b0, 1'b0, 1'b1, 32'h0000_0200);

        // Second redirect while still squashing.
        drive(1'b1, 1'b0, 1'b0, 32'h0);
        drive(1'b1, 1'b0, 1'b1, 32'h0000_0300);
        drive(1'b1, 1'b0, 1'b1, 32'h0000_0400);
        check("resq_addr", imem_addr, 32'h0000_0200);
        drive(1'b0, 1'b0, 1'b0, 32'h0);
        check("resq_next", imem_addr, 32'h0000_0400);
        repeat (3) drive(1'b0, 1'b0, 1'b0, 32'h0);

        @(posedge clk);
        chk_on = 1'b0;
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

`default_nettype wire
